// File: rtl/wishbone_host_master.sv
// ============================================================================
// wishbone_host_master : host command to single-word Wishbone cycles bridge
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wishbone_host_master #(
   parameter int TIMEOUT = 1000,
   parameter int LEN_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wr,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [31:0]      wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             done,
   output logic             timeout,
   output logic             wb_we_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   output logic [3:0]       wb_sel_o,
   output logic [31:0]      wb_adr_o,
   output logic [31:0]      wb_dat_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack_i,
   input  logic             wb_int_i,
   output logic             int_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_DATA = 3'd1,
      BUS     = 3'd2,
      RD_OUT  = 3'd3,
      FIN     = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_init;
   logic               r_wr;
   logic [31:0]        r_addr;
   logic [LEN_W-1:0]   r_rem;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_timeout;
   logic [31:0]        r_wdata;
   logic [31:0]        r_rdata;
   logic               r_int;
   logic               w_to_hit;
   logic               w_last;
   logic [31:0]        w_next_addr;

   assign w_to_hit    = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_last      = (r_rem == LEN_W'(1));
   // Slave select byte is sticky; only the offset advances and wraps.
   assign w_next_addr = {r_addr[31:24], r_addr[23:0] + 24'd1};

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
      done      = 1'b0;
      wb_cyc_o  = 1'b0;
      wb_stb_o  = 1'b0;
      wb_we_o   = 1'b0;
      wb_sel_o  = 4'h0;
      case (r_state)
         IDLE: begin
            // r_init keeps cmd_ready low while reset is still asserted.
            cmd_ready = r_init;
            if (cmd_valid && r_init) w_next = cmd_wr ? WR_DATA : BUS;
         end
         WR_DATA: begin
            wr_ready = wr_valid;
            if (wr_valid) w_next = BUS;
         end
         BUS: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = r_wr;
            wb_sel_o = 4'hF;
            if (wb_ack_i) begin
               if (!r_wr)      w_next = RD_OUT;
               else if (w_last) w_next = FIN;
               else            w_next = WR_DATA;
            end else if (w_to_hit) begin
               w_next = IDLE;
            end
         end
         RD_OUT: begin
            rd_valid = 1'b1;
            if (rd_ready) w_next = w_last ? FIN : BUS;
         end
         FIN: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_init    <= 1'b0;
         r_wr      <= 1'b0;
         r_addr    <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_int     <= 1'b0;
      end else begin
         r_init    <= 1'b1;
         r_int     <= wb_int_i;
         r_timeout <= (r_state == BUS) && !wb_ack_i && w_to_hit;
         r_cnt     <= (r_state == BUS) ? r_cnt + 1'b1 : '0;
         case (r_state)
            IDLE: begin
               if (cmd_valid && r_init) begin
                  r_wr   <= cmd_wr;
                  r_addr <= cmd_addr;
                  r_rem  <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
               end
            end
            WR_DATA: begin
               if (wr_valid) r_wdata <= wr_data;
            end
            BUS: begin
               if (wb_ack_i) begin
                  if (!r_wr) begin
                     r_rdata <= wb_dat_i;
                  end else begin
                     r_rem  <= r_rem - 1'b1;
                     r_addr <= w_next_addr;
                  end
               end
            end
            RD_OUT: begin
               if (rd_ready) begin
                  r_rem  <= r_rem - 1'b1;
                  r_addr <= w_next_addr;
               end
            end
            default: ;
         endcase
      end
   end

   assign wb_adr_o = r_addr;
   assign wb_dat_o = r_wdata;
   assign rd_data  = r_rdata;
   assign timeout  = r_timeout;
   assign int_o    = r_int;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_host_master.sv
// ============================================================================
// tb_wishbone_host_master : directed self-checking bench for wishbone_host_master
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wishbone_host_master;

   localparam int TIMEOUT = 16;
   localparam int LEN_W   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid, cmd_ready, cmd_wr;
   logic [31:0]      cmd_addr;
   logic [LEN_W-1:0] cmd_len;
   logic [31:0]      wr_data;
   logic             wr_valid, wr_ready;
   logic [31:0]      rd_data;
   logic             rd_valid, rd_ready;
   logic             done, timeout;
   logic             wb_we_o, wb_cyc_o, wb_stb_o;
   logic [3:0]       wb_sel_o;
   logic [31:0]      wb_adr_o, wb_dat_o, wb_dat_i;
   logic             wb_ack_i, wb_int_i, int_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wishbone_host_master #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .timeout(timeout),
      .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_int_i(wb_int_i), .int_o(int_o)
   );

   // Slave: acks one cycle after strobe, returns offset+1; slave 0xFF never acks.
   always @(posedge clk) begin
      if (!rst) begin
         wb_ack_i <= 1'b0;
         wb_dat_i <= '0;
      end else begin
         wb_ack_i <= wb_cyc_o && wb_stb_o && !wb_ack_i && (wb_adr_o[31:24] != 8'hFF);
         wb_dat_i <= {8'h00, wb_adr_o[23:0] + 24'd1};
      end
   end

   // Bus monitor: log completed accesses and count pulses / cycle-high clocks.
   logic [31:0] log_adr [64];
   logic [31:0] log_dat [64];
   logic        log_we  [64];
   int n_acc = 0, n_done = 0, n_to = 0, n_cyc = 0;

   always @(posedge clk) begin
      if (wb_cyc_o && wb_stb_o && wb_ack_i && n_acc < 64) begin
         log_adr[n_acc] <= wb_adr_o;
         log_dat[n_acc] <= wb_dat_o;
         log_we[n_acc]  <= wb_we_o;
         n_acc          <= n_acc + 1;
      end
      n_done <= n_done + (done     ? 1 : 0);
      n_to   <= n_to   + (timeout  ? 1 : 0);
      n_cyc  <= n_cyc  + (wb_cyc_o ? 1 : 0);
   end

   task automatic issue_cmd(input logic wr, input logic [31:0] addr,
                            input logic [LEN_W-1:0] len, output bit ok);
      int k = 0;
      ok = 1'b0;
      #1;
      while (!cmd_ready && k < 50) begin @(negedge clk); #1; k++; end
      if (cmd_ready) begin
         cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
         @(negedge clk);
         cmd_valid = 1'b0;
         ok = 1'b1;
      end
   endtask

   task automatic push_word(input logic [31:0] d, output bit ok);
      int k = 0;
      wr_data = d; wr_valid = 1'b1;
      #1;
      while (!wr_ready && k < 100) begin @(negedge clk); #1; k++; end
      ok = wr_ready;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_rd(output bit ok);
      int k = 0;
      #1;
      while (!rd_valid && k < 100) begin @(negedge clk); #1; k++; end
      ok = rd_valid;
   endtask

   task automatic take_rd();
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
   endtask

   task automatic wait_done(input int base, output bit ok);
      int k = 0;
      while (n_done == base && k < 200) begin @(negedge clk); k++; end
      ok = (n_done != base);
   endtask

   task automatic test_reset();
      rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; wb_int_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
      checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("FAIL reset_wb_ctrl: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
      checks++; if (wb_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", wb_sel_o); end
      checks++; if ({done, timeout, rd_valid, wr_ready, int_o} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {done, timeout, rd_valid, wr_ready, int_o}); end
      checks++; if ({wb_adr_o, wb_dat_o, rd_data} !== 96'h0) begin errors++; $display("FAIL reset_data: adr=%h dat=%h rd=%h want 0", wb_adr_o, wb_dat_o, rd_data); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_write();
      int b = n_acc, d0 = n_done, t0 = n_to;
      bit ok, ok1, ok2;
      issue_cmd(1'b1, 32'h0100_0010, 16'd2, ok);
      push_word(32'hA5A5_A5A5, ok1);
      push_word(32'h5A5A_5A5A, ok2);
      checks++; if (!(ok && ok1 && ok2)) begin errors++; $display("FAIL write_handshake: cmd=%0d w0=%0d w1=%0d want 1 1 1", ok, ok1, ok2); end
      wait_done(d0, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok || n_done - d0 != 1) begin errors++; $display("FAIL write_done: got %0d pulses want 1", n_done - d0); end
      checks++; if (n_acc - b != 2) begin errors++; $display("FAIL write_count: got %0d want 2", n_acc - b); end
      checks++; if (log_adr[b] !== 32'h0100_0010 || log_dat[b] !== 32'hA5A5_A5A5 || log_we[b] !== 1'b1)
         begin errors++; $display("FAIL write_word0: adr=%h dat=%h we=%b want 01000010 a5a5a5a5 1", log_adr[b], log_dat[b], log_we[b]); end
      checks++; if (log_adr[b+1] !== 32'h0100_0011 || log_dat[b+1] !== 32'h5A5A_5A5A || log_we[b+1] !== 1'b1)
         begin errors++; $display("FAIL write_word1: adr=%h dat=%h we=%b want 01000011 5a5a5a5a 1", log_adr[b+1], log_dat[b+1], log_we[b+1]); end
      checks++; if (n_to != t0) begin errors++; $display("FAIL write_no_timeout: got %0d pulses want 0", n_to - t0); end
   endtask

   task automatic test_read_backpressure();
      int b = n_acc, d0 = n_done, c0;
      bit ok;
      logic [31:0] exp_d;
      issue_cmd(1'b0, 32'h0000_0000, 16'd3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL read_cmd: accepted=%0d want 1", ok); end
      for (int i = 0; i < 3; i++) begin
         exp_d = 32'(i + 1);
         wait_rd(ok);
         checks++; if (!ok || rd_data !== exp_d) begin errors++; $display("FAIL read_word%0d: valid=%0d data=%h want %h", i, ok, rd_data, exp_d); end
         if (i == 1) begin
            c0 = n_cyc;
            for (int h = 0; h < 4; h++) begin
               @(negedge clk); #1;
               checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h2) begin errors++; $display("FAIL read_hold%0d: valid=%b data=%h want 1 00000002", h, rd_valid, rd_data); end
            end
            checks++; if (n_cyc != c0) begin errors++; $display("FAIL read_no_bus_while_pending: got %0d cyc clocks want 0", n_cyc - c0); end
         end
         take_rd();
      end
      wait_done(d0, ok);
      checks++; if (!ok || n_acc - b != 3) begin errors++; $display("FAIL read_done: done=%0d accesses=%0d want 1 3", ok, n_acc - b); end
   endtask

   task automatic test_timeout();
      int d0 = n_done, t0 = n_to, c0 = n_cyc, k = 0;
      bit ok;
      issue_cmd(1'b0, 32'hFF00_0000, 16'd1, ok);
      while (n_to == t0 && k < 100) begin @(negedge clk); k++; end
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b want 1", cmd_ready); end
      repeat (2) @(negedge clk);
      checks++; if (n_to - t0 != 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses want 1", n_to - t0); end
      checks++; if (n_cyc - c0 != TIMEOUT) begin errors++; $display("FAIL timeout_cyc_len: got %0d want %0d", n_cyc - c0, TIMEOUT); end
      checks++; if (n_done != d0) begin errors++; $display("FAIL timeout_no_done: got %0d pulses want 0", n_done - d0); end
   endtask

   task automatic test_wrap();
      int b = n_acc, d0 = n_done;
      bit ok, ok1, ok2;
      issue_cmd(1'b1, 32'h00FF_FFFF, 16'd2, ok);
      push_word(32'h1111_1111, ok1);
      push_word(32'h2222_2222, ok2);
      wait_done(d0, ok);
      checks++; if (!(ok && ok1 && ok2) || n_acc - b != 2) begin errors++; $display("FAIL wrap_done: done=%0d accesses=%0d want 1 2", ok, n_acc - b); end
      checks++; if (log_adr[b] !== 32'h00FF_FFFF) begin errors++; $display("FAIL wrap_adr0: got %h want 00ffffff", log_adr[b]); end
      checks++; if (log_adr[b+1] !== 32'h0000_0000 || log_dat[b+1] !== 32'h2222_2222) begin errors++; $display("FAIL wrap_adr1: adr=%h dat=%h want 00000000 22222222", log_adr[b+1], log_dat[b+1]); end
   endtask

   task automatic test_reset_mid();
      int d0, t0;
      bit ok;
      issue_cmd(1'b0, 32'h0000_0100, 16'd2, ok);
      #1;
      checks++; if (wb_stb_o !== 1'b1) begin errors++; $display("FAIL midrst_stb_before: got %b want 1", wb_stb_o); end
      d0 = n_done; t0 = n_to;
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if ({wb_cyc_o, wb_stb_o, rd_valid, cmd_ready} !== 4'b0000) begin errors++; $display("FAIL midrst_outputs: cyc/stb/rdv/rdy=%b want 0000", {wb_cyc_o, wb_stb_o, rd_valid, cmd_ready}); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", cmd_ready); end
      checks++; if (n_done != d0 || n_to != t0) begin errors++; $display("FAIL midrst_no_pulse: done=%0d timeout=%0d want 0 0", n_done - d0, n_to - t0); end
      d0 = n_done;
      issue_cmd(1'b0, 32'h0000_0005, 16'd1, ok);
      wait_rd(ok);
      checks++; if (!ok || rd_data !== 32'h6) begin errors++; $display("FAIL midrst_new_read: valid=%0d data=%h want 1 00000006", ok, rd_data); end
      take_rd();
      wait_done(d0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_new_done: got %0d want 1", ok); end
   endtask

   task automatic test_len0_int();
      int b = n_acc, d0 = n_done;
      bit ok;
      issue_cmd(1'b0, 32'h0000_0020, 16'd0, ok);
      wait_rd(ok);
      checks++; if (!ok || rd_data !== 32'h21) begin errors++; $display("FAIL len0_data: valid=%0d data=%h want 1 00000021", ok, rd_data); end
      take_rd();
      wait_done(d0, ok);
      repeat (3) @(negedge clk);
      checks++; if (!ok || n_acc - b != 1 || n_done - d0 != 1) begin errors++; $display("FAIL len0_single: accesses=%0d done=%0d want 1 1", n_acc - b, n_done - d0); end
      wb_int_i = 1'b1;
      #1;
      checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL int_not_early: got %b want 0", int_o); end
      @(negedge clk);
      checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL int_delayed: got %b want 1", int_o); end
      wb_int_i = 1'b0;
      @(negedge clk);
      checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL int_clear: got %b want 0", int_o); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_backpressure();
      test_timeout();
      test_wrap();
      test_reset_mid();
      test_len0_int();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
